fetch_stage: RTL

- Instruction-fetch stage plus IF/ID pipeline register for the 5-stage 64-bit LEGv8 pipeline.
- Owns the PC and issues one-outstanding requests to a variable-latency instruction memory.
- Presents instruction and PC to decode through the IF/ID register.
- Accepts stall from the hazard unit and taken-branch redirects; the branch offset is the sign-extended word offset that decode produces.

---
 rtl/pipeline_pkg.sv | 28 ++
 rtl/branch_target_adder.sv | 18 +
 rtl/fetch_stage.sv | 124 ++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// ============================================================================
// Module      : pipeline_pkg
// Description : Types and constants shared across the LEGv8 pipeline stages.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_pkg;

  // Canonical architectural NOP encoding, used for bubbles and flushes.
  localparam logic [31:0] NOP_INSTR = 32'hD503201F;

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instruction;
    logic [63:0] pc;
    logic        valid;
  } ifid_t;

endpackage : pipeline_pkg

`default_nettype wire

// File: rtl/branch_target_adder.sv
// ============================================================================
// Module      : branch_target_adder
// Description : 64-bit branch target, base + (word offset << 2), wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_target_adder (
  input  logic [63:0] i_base,
  input  logic [63:0] i_offset,
  output logic [63:0] o_target
);

  assign o_target = i_base + {i_offset[61:0], 2'b00};

endmodule : branch_target_adder

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch with one-outstanding memory requests and the
//               IF/ID pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [63:0] br_pc,
  input  logic [63:0] br_offset,
  output logic [31:0] IFID_instruction,
  output logic [63:0] IFID_pc,
  output logic        IFID_valid
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [63:0]  r_pc;
  logic [63:0]  w_pc_nxt;
  ifid_t        r_ifid;
  ifid_t        w_ifid_nxt;
  logic [31:0]  r_skid;
  logic [31:0]  w_skid_nxt;
  logic         r_run;
  logic         w_req;
  logic [63:0]  w_br_target;

  branch_target_adder u_br_adder (
    .i_base   (br_pc),
    .i_offset (br_offset),
    .o_target (w_br_target)
  );

  // r_run keeps the first request off until the first edge after reset release.
  assign w_req = r_run && (r_state == ISSUE);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ifid_nxt  = r_ifid;
    w_skid_nxt  = r_skid;

    if (br_taken) begin
      w_pc_nxt   = w_br_target;
      w_ifid_nxt = '{instruction: NOP_INSTR, pc: 64'h0, valid: 1'b0};
      case (r_state)
        ISSUE:      w_state_nxt = w_req ? DROP : ISSUE;
        WAIT, DROP: w_state_nxt = imem_valid ? ISSUE : DROP;
        default:    w_state_nxt = ISSUE;
      endcase
    end else begin
      case (r_state)
        ISSUE: begin
          if (w_req) w_state_nxt = WAIT;
        end
        WAIT: begin
          if (imem_valid) begin
            if (stall) begin
              w_skid_nxt  = imem_rdata;
              w_state_nxt = HOLD;
            end else begin
              w_ifid_nxt  = '{instruction: imem_rdata, pc: r_pc, valid: 1'b1};
              w_pc_nxt    = r_pc + 64'd4;
              w_state_nxt = ISSUE;
            end
          end else if (!stall) begin
            w_ifid_nxt.instruction = NOP_INSTR;
            w_ifid_nxt.valid       = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            w_ifid_nxt  = '{instruction: r_skid, pc: r_pc, valid: 1'b1};
            w_pc_nxt    = r_pc + 64'd4;
            w_state_nxt = ISSUE;
          end
        end
        DROP: begin
          if (imem_valid) w_state_nxt = ISSUE;
        end
        default: w_state_nxt = ISSUE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ISSUE;
      r_pc    <= RESET_PC;
      r_ifid  <= '{instruction: NOP_INSTR, pc: 64'h0, valid: 1'b0};
      r_skid  <= 32'h0;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ifid  <= w_ifid_nxt;
      r_skid  <= w_skid_nxt;
      r_run   <= 1'b1;
    end
  end

  assign imem_req         = w_req;
  assign imem_addr        = r_pc;
  assign IFID_instruction = r_ifid.instruction;
  assign IFID_pc          = r_ifid.pc;
  assign IFID_valid       = r_ifid.valid;

endmodule : fetch_stage

`default_nettype wire
